// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl: pipeline control unit for the RISC-V core.
//
// Combines per-requester stall requests into a per-stage stall vector. That
// vector covers the PC and every pipeline register up to the deepest stage
// that any active requester maps to. Flushes from the flush stage are
// sequenced here: a flush that cannot issue because its stage is stalled is
// held pending until it can. Saturating debug counters track stalled cycles
// and issued flushes. A sticky flag records any stall run of TIMEOUT cycles.
//
// Ports:
//   clk              clock, rising edge
//   rst              synchronous active-high reset; also forces outputs to 0
//   rdy              global ready; 0 freezes the whole pipeline
//   stall_req_i      per-requester stall request (level)
//   flush_req_i      flush request from FLUSH_STAGE (level)
//   cnt_clr_i        synchronous clear of both performance counters
//   stall_o          per-stage stall, 1 = hold register
//   flush_o          per-stage flush, 1 = load bubble
//   flush_pending_o  a flush is latched and waiting to issue
//   stall_timeout_o  sticky stall-timeout flag
//   stall_cnt_o      stalled-cycle counter (saturating)
//   flush_cnt_o      issued-flush counter (saturating)
// -----------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int unsigned         STAGES      = 6,
   parameter int unsigned         NREQ        = 4,
   parameter logic [8*NREQ-1:0]   STAGE_MAP   = 32'h04030201,
   parameter int unsigned         FLUSH_STAGE = 3,
   parameter int unsigned         TIMEOUT     = 1024,
   parameter int unsigned         CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic [NREQ-1:0]   stall_req_i,
   input  logic              flush_req_i,
   input  logic              cnt_clr_i,
   output logic [STAGES-1:0] stall_o,
   output logic [STAGES-1:0] flush_o,
   output logic              flush_pending_o,
   output logic              stall_timeout_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   localparam int unsigned RUN_W     = $clog2(TIMEOUT + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT);

   logic [STAGES-1:0] stall_raw;
   logic [STAGES-1:0] stall_vec;
   logic [STAGES-1:0] flush_mask;
   logic [7:0]        depth;
   logic              any_req;
   logic              want;
   logic              issue;
   logic              stalled;

   logic              pending_q, pending_d;
   logic              timeout_q, timeout_d;
   logic [RUN_W-1:0]  run_q,     run_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   // Stall merge: find the deepest stage mapped by any active requester and
   // stall every register at or before it. A global not-ready freezes all.
   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      depth     = '0;
      any_req   = 1'b0;
      stall_raw = '0;
      // NOTE: blocking assignments in combinational logic, so later
      // statements see the updated value within the same evaluation.
      for (int i = 0; i < NREQ; i++) begin
         if (stall_req_i[i]) begin
            any_req = 1'b1;
            if (STAGE_MAP[8*i +: 8] > depth) depth = STAGE_MAP[8*i +: 8];
         end
      end
      for (int k = 0; k < STAGES; k++) begin
         stall_raw[k] = any_req && (8'(k) <= depth);
      end
      if (!rdy) stall_raw = '1;
      stall_vec = rst ? '0 : stall_raw;
   end

   // Flush sequencing. A flush kills the registers from stage 1 up to the
   // flush stage, and it can only issue while that stage is not held.
   always_comb begin
      flush_mask = '0;
      for (int k = 1; k < STAGES; k++) begin
         flush_mask[k] = (k <= FLUSH_STAGE);
      end
      want      = flush_req_i | pending_q;
      issue     = want & rdy & ~stall_vec[FLUSH_STAGE] & ~rst;
      // Requests arriving while one is already pending merge into one issue.
      pending_d = want & ~issue;
   end

   // Counters and the stall-timeout tracker.
   always_comb begin
      stalled     = rdy & (|stall_vec);

      stall_cnt_d = stall_cnt_q;
      if (cnt_clr_i)                            stall_cnt_d = '0;
      else if (stalled && stall_cnt_q != '1)    stall_cnt_d = stall_cnt_q + 1'b1;

      flush_cnt_d = flush_cnt_q;
      if (cnt_clr_i)                            flush_cnt_d = '0;
      else if (issue && flush_cnt_q != '1)      flush_cnt_d = flush_cnt_q + 1'b1;

      // The run counter measures consecutive stalled cycles. It freezes while
      // the pipeline is not ready and restarts on any free-running cycle.
      run_d = run_q;
      if (rdy) begin
         if (|stall_vec) begin
            if (run_q != RUN_MAX) run_d = run_q + 1'b1;
         end else begin
            run_d = '0;
         end
      end

      // Sticky: only reset clears it, not the counter clear.
      timeout_d = timeout_q | (run_d == RUN_MAX);
   end

   // NOTE: reset is synchronous here, so it appears only inside the clocked
   // branch and not in the sensitivity list.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all state, so every register
      // samples values from before the edge regardless of statement order.
      if (rst) begin
         pending_q   <= 1'b0;
         timeout_q   <= 1'b0;
         run_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         pending_q   <= pending_d;
         timeout_q   <= timeout_d;
         run_q       <= run_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // While rst is high every output reads 0, including the registered ones.
   assign stall_o         = stall_vec;
   assign flush_o         = issue ? flush_mask : '0;
   assign flush_pending_o = ~rst & pending_q;
   assign stall_timeout_o = ~rst & timeout_q;
   assign stall_cnt_o     = rst ? '0 : stall_cnt_q;
   assign flush_cnt_o     = rst ? '0 : flush_cnt_q;

endmodule
